// File: rtl/blink_pkg.sv
// Shared types and the stored pattern table for the pattern blinker.
package blink_pkg;

    localparam int PAT_W      = 2;
    localparam int PAT_TICK_W = 8;
    localparam int PAT_CNT_W  = 4;

    typedef struct packed {
        logic [PAT_TICK_W-1:0] on_ticks;
        logic [PAT_TICK_W-1:0] off_ticks;
        logic [PAT_CNT_W-1:0]  count;
    } blink_pattern_t;

    // Indexed by pattern_sel; count of 0 means repeat until aborted.
    localparam blink_pattern_t [3:0] PATTERNS = {
        blink_pattern_t'{8'd1, 8'd1,  4'd10},  // 3: alarm
        blink_pattern_t'{8'd1, 8'd9,  4'd0},   // 2: heartbeat
        blink_pattern_t'{8'd2, 8'd2,  4'd5},   // 1: success
        blink_pattern_t'{8'd5, 8'd10, 4'd3}    // 0: error
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_DONE = 2'd3
    } blink_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides hwclk down to a one-cycle tick every TICK_CYCLES cycles, restartable by clear.
module tick_prescaler #(
    parameter int TICK_CYCLES = 1200000
) (
    input  logic hwclk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == LAST);

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pattern_blinker.sv
// Plays one of four stored blink patterns on a masked LED group; level start, done pulse, abort.
module pattern_blinker
    import blink_pkg::*;
#(
    parameter int TICK_CYCLES = 1200000,
    parameter int LED_W       = 4,
    parameter int TICK_W      = 8,
    parameter int CNT_W       = 4
) (
    input  logic             hwclk,
    input  logic             rst,
    input  logic             start_blinking,
    input  logic [PAT_W-1:0] pattern_sel,
    input  logic [LED_W-1:0] led_mask,
    input  logic             abort,
    output logic [LED_W-1:0] led,
    output logic             busy,
    output logic             done_blinking
);

    blink_state_t r_state, w_state_next;

    logic              r_start_prev;
    logic [TICK_W-1:0] r_on, r_off, w_on_next, w_off_next;
    logic [CNT_W-1:0]  r_count, w_count_next;
    logic [LED_W-1:0]  r_mask, w_mask_next;
    logic [TICK_W-1:0] r_tick_cnt, w_tick_cnt_next;
    logic [CNT_W-1:0]  r_blink_cnt, w_blink_next;
    logic [LED_W-1:0]  r_led, w_led_next;
    logic              r_busy, w_busy_next;
    logic              r_done, w_done_next;

    logic              w_start_edge, w_accept, w_clear, w_tick, w_phase_end;
    logic [TICK_W-1:0] w_on_last, w_off_last, w_phase_last;
    logic [CNT_W-1:0]  w_blink_inc;

    tick_prescaler #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_prescaler (
        .hwclk(hwclk),
        .rst  (rst),
        .clear(w_clear),
        .tick (w_tick)
    );

    assign w_start_edge = start_blinking && !r_start_prev;
    assign w_accept     = (r_state == ST_IDLE) && w_start_edge && !abort;

    // Zero-length phases are stretched to a single tick.
    assign w_on_last    = (r_on  == '0) ? '0 : r_on  - TICK_W'(1);
    assign w_off_last   = (r_off == '0) ? '0 : r_off - TICK_W'(1);
    assign w_phase_last = (r_state == ST_ON) ? w_on_last : w_off_last;
    assign w_phase_end  = w_tick && (r_tick_cnt == w_phase_last);
    assign w_blink_inc  = r_blink_cnt + CNT_W'(1);

    always_comb begin
        w_state_next    = r_state;
        w_clear         = 1'b0;
        w_tick_cnt_next = r_tick_cnt;
        w_blink_next    = r_blink_cnt;
        w_on_next       = r_on;
        w_off_next      = r_off;
        w_count_next    = r_count;
        w_mask_next     = r_mask;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next    = ST_ON;
                    w_clear         = 1'b1;
                    w_tick_cnt_next = '0;
                    w_blink_next    = '0;
                    w_on_next       = TICK_W'(PATTERNS[pattern_sel].on_ticks);
                    w_off_next      = TICK_W'(PATTERNS[pattern_sel].off_ticks);
                    w_count_next    = CNT_W'(PATTERNS[pattern_sel].count);
                    w_mask_next     = led_mask;
                end
            end
            ST_ON: begin
                if (abort) begin
                    w_state_next    = ST_IDLE;
                    w_clear         = 1'b1;
                    w_tick_cnt_next = '0;
                end else if (w_phase_end) begin
                    w_state_next    = ST_OFF;
                    w_clear         = 1'b1;
                    w_tick_cnt_next = '0;
                end else if (w_tick) begin
                    w_tick_cnt_next = r_tick_cnt + TICK_W'(1);
                end
            end
            ST_OFF: begin
                if (abort) begin
                    w_state_next    = ST_IDLE;
                    w_clear         = 1'b1;
                    w_tick_cnt_next = '0;
                end else if (w_phase_end) begin
                    w_clear         = 1'b1;
                    w_tick_cnt_next = '0;
                    w_blink_next    = w_blink_inc;
                    if ((r_count != '0) && (w_blink_inc == r_count)) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_ON;
                    end
                end else if (w_tick) begin
                    w_tick_cnt_next = r_tick_cnt + TICK_W'(1);
                end
            end
            ST_DONE: begin
                w_state_next    = ST_IDLE;
                w_clear         = 1'b1;
                w_tick_cnt_next = '0;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_clear      = 1'b1;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        w_led_next  = (w_state_next == ST_ON) ? w_mask_next : '0;
        w_busy_next = (w_state_next != ST_IDLE);
        w_done_next = (w_state_next == ST_DONE);
    end

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_start_prev <= 1'b0;
            r_on         <= '0;
            r_off        <= '0;
            r_count      <= '0;
            r_mask       <= '0;
            r_tick_cnt   <= '0;
            r_blink_cnt  <= '0;
            r_led        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_start_prev <= start_blinking;
            r_on         <= w_on_next;
            r_off        <= w_off_next;
            r_count      <= w_count_next;
            r_mask       <= w_mask_next;
            r_tick_cnt   <= w_tick_cnt_next;
            r_blink_cnt  <= w_blink_next;
            r_led        <= w_led_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
        end
    end

    assign led           = r_led;
    assign busy          = r_busy;
    assign done_blinking = r_done;

endmodule

// File: tb/tb_pattern_blinker.sv
// Scoreboard bench: stimulus queues expected output changes; a monitor matches every change.
module tb_pattern_blinker;

    localparam int TC = 4;

    logic       hwclk = 1'b0;
    logic       rst;
    logic       start_blinking;
    logic [1:0] pattern_sel;
    logic [3:0] led_mask;
    logic       abort;
    logic [3:0] led;
    logic       busy;
    logic       done_blinking;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [3:0] led;
        logic       busy;
        logic       done;
    } ev_t;

    ev_t exp_q[$];

    pattern_blinker #(
        .TICK_CYCLES(TC),
        .LED_W      (4),
        .TICK_W     (8),
        .CNT_W      (4)
    ) dut (
        .hwclk         (hwclk),
        .rst           (rst),
        .start_blinking(start_blinking),
        .pattern_sel   (pattern_sel),
        .led_mask      (led_mask),
        .abort         (abort),
        .led           (led),
        .busy          (busy),
        .done_blinking (done_blinking)
    );

    always #5 hwclk = ~hwclk;
    always @(posedge hwclk) cyc <= cyc + 1;

    task automatic push_ev(input int c, input logic [3:0] l, input logic b, input logic d);
        ev_t e;
        e.cyc  = c;
        e.led  = l;
        e.busy = b;
        e.done = d;
        exp_q.push_back(e);
    endtask

    // Edge in cycle t0: first ON at t0+1, done at t0+1+cnt*(on+off)*TC, idle one cycle later.
    task automatic push_run(input int t0, input int on, input int off, input int cnt,
                            input logic [3:0] m);
        int per;
        per = (on + off) * TC;
        for (int b = 0; b < cnt; b++) begin
            push_ev(t0 + 1 + b * per, m, 1'b1, 1'b0);
            push_ev(t0 + 1 + b * per + on * TC, 4'b0000, 1'b1, 1'b0);
        end
        push_ev(t0 + 1 + cnt * per, 4'b0000, 1'b1, 1'b1);
        push_ev(t0 + 2 + cnt * per, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge hwclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s = %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor: every observed change of {led,busy,done} must match the queue head exactly.
    initial begin
        logic [5:0] prev_out;
        logic [5:0] cur_out;
        ev_t        e;
        prev_out = 6'b0;
        forever begin
            @(negedge hwclk);
            cur_out = {led, busy, done_blinking};
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_event: no change seen at cycle %0d, required led=%b busy=%b done=%b",
                         exp_q[0].cyc, exp_q[0].led, exp_q[0].busy, exp_q[0].done);
                void'(exp_q.pop_front());
            end
            if (cur_out !== prev_out) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: cycle %0d got led=%b busy=%b done=%b, required no change",
                             cyc, led, busy, done_blinking);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || {e.led, e.busy, e.done} !== cur_out) begin
                        errors++;
                        $display("FAIL event: got cycle %0d led=%b busy=%b done=%b, required cycle %0d led=%b busy=%b done=%b",
                                 cyc, led, busy, done_blinking, e.cyc, e.led, e.busy, e.done);
                    end else begin
                        $display("ok   event cycle %0d led=%b busy=%b done=%b",
                                 cyc, led, busy, done_blinking);
                    end
                end
                prev_out = cur_out;
            end
        end
    end

    initial begin
        int t0;
        rst            = 1'b0;
        start_blinking = 1'b0;
        abort          = 1'b0;
        pattern_sel    = 2'd0;
        led_mask       = 4'b0000;
        #1 rst = 1'b1;
        step(3);
        check("reset_led", led, 4'b0000);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done_blinking, 1'b0);
        rst = 1'b0;
        step(2);

        // 1: success pattern, 8 on / 8 off x5, done at t0+81, idle at t0+82.
        t0 = cyc;
        pattern_sel = 2'd1;
        led_mask = 4'b0101;
        start_blinking = 1'b1;
        push_run(t0, 2, 2, 5, 4'b0101);
        step(1);
        start_blinking = 1'b0;
        step(85);
        check("t1_busy_after", busy, 1'b0);

        // 2: error pattern with start held high: one run, no retrigger.
        t0 = cyc;
        pattern_sel = 2'd0;
        led_mask = 4'b1111;
        start_blinking = 1'b1;
        push_run(t0, 5, 10, 3, 4'b1111);
        step(250);
        check("t2_no_retrigger_busy", busy, 1'b0);
        start_blinking = 1'b0;
        step(3);

        // 4: alarm pattern, second edge mid-run with different sel/mask is ignored.
        t0 = cyc;
        pattern_sel = 2'd3;
        led_mask = 4'b1010;
        start_blinking = 1'b1;
        push_run(t0, 1, 1, 10, 4'b1010);
        step(2);
        start_blinking = 1'b0;
        step(18);
        pattern_sel = 2'd0;
        led_mask = 4'b1111;
        start_blinking = 1'b1;
        step(5);
        start_blinking = 1'b0;
        step(65);

        // 3: heartbeat forever, 40-cycle blinks; abort during the 51st ON phase.
        t0 = cyc;
        pattern_sel = 2'd2;
        led_mask = 4'b0011;
        start_blinking = 1'b1;
        for (int b = 0; b <= 50; b++) begin
            push_ev(t0 + 1 + 40 * b, 4'b0011, 1'b1, 1'b0);
            if (b < 50) push_ev(t0 + 5 + 40 * b, 4'b0000, 1'b1, 1'b0);
        end
        step(2);
        start_blinking = 1'b0;
        step(2000);
        check("t3_busy_forever", busy, 1'b1);
        check("t3_led_on", led, 4'b0011);
        abort = 1'b1;
        push_ev(cyc + 1, 4'b0000, 1'b0, 1'b0);
        step(1);
        check("t3_abort_led", led, 4'b0000);
        check("t3_abort_busy", busy, 1'b0);
        abort = 1'b0;
        step(20);

        // 5: abort with a start edge in IDLE: not accepted, no later retrigger.
        pattern_sel = 2'd1;
        led_mask = 4'b1111;
        abort = 1'b1;
        start_blinking = 1'b1;
        step(1);
        abort = 1'b0;
        check("t5_busy_next", busy, 1'b0);
        step(5);
        check("t5_busy_later", busy, 1'b0);
        start_blinking = 1'b0;
        step(2);

        // 6: asynchronous reset in the middle of an ON phase.
        t0 = cyc;
        pattern_sel = 2'd1;
        led_mask = 4'b1111;
        start_blinking = 1'b1;
        push_ev(t0 + 1, 4'b1111, 1'b1, 1'b0);
        step(2);
        start_blinking = 1'b0;
        step(2);
        push_ev(cyc, 4'b0000, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("t6_async_led", led, 4'b0000);
        check("t6_async_busy", busy, 1'b0);
        step(2);
        rst = 1'b0;
        step(5);

        step(3);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
